// File: rtl/test_crc_fp_multi.sv
// CRC-32 fingerprint sink: folds valid/ready words MSB byte first into a table-driven CRC
// and compares the running value against NUM_CHK expected fingerprints.
module test_crc_fp_multi #(
  parameter int                    DATA_BYTES   = 4,
  parameter int                    CHK_INTERVAL = 512,
  parameter int                    NUM_CHK      = 2,
  parameter logic [31:0]           CRC_INIT     = 32'h0,
  parameter logic [32*NUM_CHK-1:0] EXPECTED     = {32'h866862DF, 32'h62D5B636}
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         test_ready_out,
  input  logic                         test_valid_in,
  input  logic [8*DATA_BYTES-1:0]      test_data_in,
  output logic                         test_step,
  output logic                         test_good,
  output logic                         test_fail,
  output logic [$clog2(NUM_CHK+1)-1:0] test_chk_idx,
  output logic                         test_ended,
  output logic [31:0]                  test_crc
);

  localparam int          IW   = $clog2(NUM_CHK + 1);
  localparam int          CW   = $clog2(CHK_INTERVAL * NUM_CHK + 1);
  localparam int          KW   = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  typedef enum logic [1:0] {S_IDLE, S_BYTE, S_FINAL} state_t;

  state_t                  state, state_n;
  logic [KW-1:0]           k, k_n;
  logic [8*DATA_BYTES-1:0] data_q;
  logic [31:0]             crc, tbl_out, crc_new, crc_base;
  logic [CW-1:0]           word_cnt;
  logic [IW-1:0]           chk_idx;
  logic                    step_q, good_q, fail_q, ended_q;
  logic                    crc_we, ready, lookup, load;
  logic [7:0]              byte_in, ctrl;
  logic [31:0]             chk_target;
  logic                    hit, match, ended_next;

  // Table entries are generated from the polynomial, so the ROM needs no external data file.
  function automatic logic [31:0] crc_tbl(input logic [7:0] idx);
    logic [31:0] r;
    r = {idx, 24'h0};
    for (int b = 0; b < 8; b++)
      r = r[31] ? ({r[30:0], 1'b0} ^ POLY) : {r[30:0], 1'b0};
    return r;
  endfunction

  assign crc_new    = {crc[23:0], 8'h00} ^ tbl_out;
  assign crc_base   = crc_we ? crc_new : crc;
  assign byte_in    = load ? test_data_in[8*DATA_BYTES-1 -: 8]
                           : data_q[8*(DATA_BYTES-1-int'(k)) +: 8];
  assign ctrl       = crc_base[31:24] ^ byte_in;

  assign chk_target = 32'(CHK_INTERVAL) * (32'(chk_idx) + 32'd1);
  assign hit        = (state == S_FINAL) && ((32'(word_cnt) + 32'd1) == chk_target);
  assign match      = (crc_new == EXPECTED[32*int'(chk_idx) +: 32]);
  assign ended_next = hit && (chk_idx == IW'(NUM_CHK - 1));

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = S_IDLE;
    k_n     = k;
    crc_we  = 1'b0;
    ready   = 1'b0;
    lookup  = 1'b0;
    load    = 1'b0;
    case (state)
      S_IDLE: begin
        ready = !ended_q;
      end
      S_BYTE: begin
        crc_we = 1'b1;
        lookup = 1'b1;
        if (k == KW'(DATA_BYTES - 1)) begin
          state_n = S_FINAL;
        end else begin
          state_n = S_BYTE;
          k_n     = k + KW'(1);
        end
      end
      S_FINAL: begin
        crc_we = 1'b1;
        ready  = !ended_next;
      end
      default: state_n = S_IDLE;
    endcase
    // A word accepted in IDLE or FINAL starts its MSB lookup in the same cycle.
    if (ready && test_valid_in) begin
      lookup = 1'b1;
      load   = 1'b1;
      if (DATA_BYTES == 1) begin
        state_n = S_FINAL;
      end else begin
        state_n = S_BYTE;
        k_n     = KW'(1);
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: datapath registers are reset too, so an aborted word leaves nothing behind.
      state    <= S_IDLE;
      k        <= '0;
      data_q   <= '0;
      tbl_out  <= '0;
      crc      <= CRC_INIT;
      word_cnt <= '0;
      chk_idx  <= '0;
      step_q   <= 1'b0;
      good_q   <= 1'b0;
      fail_q   <= 1'b0;
      ended_q  <= 1'b0;
    end else begin
      state  <= state_n;
      k      <= k_n;
      step_q <= hit;
      good_q <= hit && match;
      if (load)   data_q  <= test_data_in;
      if (lookup) tbl_out <= crc_tbl(ctrl);
      if (crc_we) crc     <= crc_new;
      if (state == S_FINAL) word_cnt <= word_cnt + CW'(1);
      if (hit) begin
        fail_q  <= fail_q | !match;
        chk_idx <= chk_idx + IW'(1);
        ended_q <= ended_next;
      end
    end
  end

  assign test_ready_out = ready;
  assign test_step      = step_q;
  assign test_good      = good_q;
  assign test_fail      = fail_q;
  assign test_chk_idx   = chk_idx;
  assign test_ended     = ended_q;
  assign test_crc       = crc;

endmodule
